// File: rtl/serial_adder4_if.sv
// Operand/result bundle for serial_adder4.
// Optional ovf signal exists only when SERIAL_ADDER4_OVF_EN is defined.
interface serial_adder4_if;
    logic       start;
    logic [3:0] a;
    logic [3:0] b;
    logic       cin;
    logic       busy;
    logic       done;
    logic [3:0] sum;
    logic       cout;
`ifdef SERIAL_ADDER4_OVF_EN
    logic       ovf;

    modport master (
        output start, a, b, cin,
        input  busy, done, sum, cout, ovf
    );

    modport slave (
        input  start, a, b, cin,
        output busy, done, sum, cout, ovf
    );
`else
    modport master (
        output start, a, b, cin,
        input  busy, done, sum, cout
    );

    modport slave (
        input  start, a, b, cin,
        output busy, done, sum, cout
    );
`endif
endinterface

// File: rtl/serial_adder4.sv
// Bit-serial 4-bit adder, one full-adder cell, LSB first, 4 cycles per op.
// Optional signed-overflow output enabled by SERIAL_ADDER4_OVF_EN.
module serial_adder4 (
    input  logic          clk,
    input  logic          rst,
    serial_adder4_if.slave bus
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t     state;
    state_t     state_nx;

    logic [3:0] ra;
    logic [3:0] rb;
    logic [2:0] acc;
    logic       c;
    logic [1:0] cnt;

    logic       load;
    logic       step;
    logic       last;

    logic       fs;
    logic       fc;

    logic [3:0] sum_q;
    logic       cout_q;
    logic       done_q;

    // single full-adder cell on the current LSBs and carry
    assign fs = ra[0] ^ rb[0] ^ c;
    assign fc = (ra[0] & rb[0]) | (c & (ra[0] ^ rb[0]));

    // state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // next-state and step control; start is only looked at in IDLE
    always_comb begin
        state_nx = state;
        load     = 1'b0;
        step     = 1'b0;
        last     = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    load     = 1'b1;
                    state_nx = RUN;
                end
            end
            RUN: begin
                step = 1'b1;
                if (cnt == 2'd3) begin
                    last     = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // operand shifters, carry and bit counter; partial sum enters from MSB
    always_ff @(posedge clk) begin
        if (rst) begin
            ra  <= 4'd0;
            rb  <= 4'd0;
            acc <= 3'd0;
            c   <= 1'b0;
            cnt <= 2'd0;
        end else if (load) begin
            ra  <= bus.a;
            rb  <= bus.b;
            c   <= bus.cin;
            cnt <= 2'd0;
        end else if (step) begin
            ra  <= {1'b0, ra[3:1]};
            rb  <= {1'b0, rb[3:1]};
            acc <= {fs, acc[2:1]};
            c   <= fc;
            cnt <= cnt + 2'd1;
        end
    end

    // result registers change only on the final bit; done is a 1-cycle pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q  <= 4'd0;
            cout_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= last;
            if (last) begin
                sum_q  <= {fs, acc};
                cout_q <= fc;
            end
        end
    end

`ifdef SERIAL_ADDER4_OVF_EN
    logic ovf_q;

    // overflow = carry into bit 3 xor carry out of bit 3
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (last) begin
            ovf_q <= c ^ fc;
        end
    end

    assign bus.ovf = ovf_q;
`endif

    assign bus.busy = (state == RUN);
    assign bus.done = done_q;
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;

endmodule

// File: tb/tb_serial_adder4.sv
// Directed self-checking bench for serial_adder4.
// Build with SERIAL_ADDER4_OVF_EN to also cover the ovf output.
module tb_serial_adder4;

    logic clk;
    logic rst;
    int   n_chk;
    int   n_pass;

    serial_adder4_if bus ();

    serial_adder4 dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // launch one op (start seen at next edge), return edges until done
    task automatic run_op(input logic [3:0] a, input logic [3:0] b,
                          input logic ci, output int lat);
        bus.start = 1'b1;
        bus.a     = a;
        bus.b     = b;
        bus.cin   = ci;
        tick();
        bus.start = 1'b0;
        lat = 0;
        while (bus.done !== 1'b1 && lat < 10) begin
            tick();
            lat++;
        end
    endtask

    int lat;
    int ndone;
    int bad;
    logic [4:0] expv;

    initial begin
        n_chk     = 0;
        n_pass    = 0;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.a     = 4'd0;
        bus.b     = 4'd0;
        bus.cin   = 1'b0;
        tick();
        tick();
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_sum", 32'(bus.sum), 32'd0);
        check("rst_cout", 32'(bus.cout), 32'd0);
        rst = 1'b0;
        tick();

        // basic 5+3
        bus.start = 1'b1;
        bus.a = 4'h5;
        bus.b = 4'h3;
        bus.cin = 1'b0;
        tick();
        bus.start = 1'b0;
        check("busy_after_start", 32'(bus.busy), 32'd1);
        lat = 0;
        while (bus.done !== 1'b1 && lat < 10) begin
            tick();
            lat++;
        end
        check("basic_lat", 32'(lat), 32'd4);
        check("basic_sum", 32'(bus.sum), 32'h8);
        check("basic_cout", 32'(bus.cout), 32'd0);
        check("basic_busy", 32'(bus.busy), 32'd0);
        tick();
        check("done_pulse", 32'(bus.done), 32'd0);
        check("sum_hold_idle", 32'(bus.sum), 32'h8);

        // carry and wrap
        run_op(4'hF, 4'h1, 1'b1, lat);
        check("wrap_lat", 32'(lat), 32'd4);
        check("wrap_sum", 32'(bus.sum), 32'h1);
        check("wrap_cout", 32'(bus.cout), 32'd1);
        tick();

`ifdef SERIAL_ADDER4_OVF_EN
        check("ovf_prev", 32'(bus.ovf), 32'd0);
        run_op(4'h7, 4'h1, 1'b0, lat);
        check("ovf_sum", 32'(bus.sum), 32'h8);
        check("ovf_set", 32'(bus.ovf), 32'd1);
        tick();
        run_op(4'h8, 4'h8, 1'b0, lat);
        check("ovf_neg_sum", 32'(bus.sum), 32'h0);
        check("ovf_neg", 32'(bus.ovf), 32'd1);
        tick();
        run_op(4'h2, 4'h3, 1'b0, lat);
        check("ovf_clr", 32'(bus.ovf), 32'd0);
        tick();
`endif

        // start held high and operands changed while busy
        bus.start = 1'b1;
        bus.a = 4'h2;
        bus.b = 4'h3;
        bus.cin = 1'b0;
        tick();
        bus.a = 4'hF;
        bus.b = 4'hF;
        bus.cin = 1'b1;
        lat = 0;
        while (bus.done !== 1'b1 && lat < 10) begin
            tick();
            lat++;
        end
        bus.start = 1'b0;
        check("ign_lat", 32'(lat), 32'd4);
        check("ign_sum", 32'(bus.sum), 32'h5);
        check("ign_cout", 32'(bus.cout), 32'd0);
        ndone = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (bus.done === 1'b1) ndone++;
        end
        check("ign_single_done", 32'(ndone), 32'd0);

        // back-to-back: start raised in the done cycle
        run_op(4'h1, 4'h2, 1'b0, lat);
        check("b2b_first", 32'(bus.sum), 32'h3);
        run_op(4'hA, 4'h6, 1'b0, lat);
        check("b2b_lat", 32'(lat), 32'd4);
        check("b2b_sum", 32'(bus.sum), 32'h0);
        check("b2b_cout", 32'(bus.cout), 32'd1);

        // sum holds previous result during RUN
        bus.start = 1'b1;
        bus.a = 4'h4;
        bus.b = 4'h4;
        bus.cin = 1'b0;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        check("sum_hold_run", 32'(bus.sum), 32'h0);
        check("cout_hold_run", 32'(bus.cout), 32'd1);
        check("done_low_run", 32'(bus.done), 32'd0);
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        ndone = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (bus.done === 1'b1) ndone++;
        end
        check("abort_no_done", 32'(ndone), 32'd0);
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_sum", 32'(bus.sum), 32'd0);
        check("abort_cout", 32'(bus.cout), 32'd0);

        // exhaustive a, b, cin
        bad = 0;
        for (int i = 0; i < 512; i++) begin
            logic [3:0] ea;
            logic [3:0] eb;
            logic       ec;
            ea = 4'(i);
            eb = 4'(i >> 4);
            ec = 1'(i >> 8);
            expv = 5'(ea) + 5'(eb) + 5'(ec);
            run_op(ea, eb, ec, lat);
            if (lat != 4 || {bus.cout, bus.sum} !== expv) bad++;
            check($sformatf("exh_%0h_%0h_%0d", ea, eb, ec),
                  32'({bus.cout, bus.sum}), 32'(expv));
        end
        check("exh_lat_errs", 32'(bad), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
